cp0_intctrl: RTL and testbench
==============================

Name: cp0_intctrl

Overview:
- Interrupt pending/request stage that feeds the CP0 Status/exception logic.
- Synchronizes external interrupt lines and merges the timer and software interrupt bits into the Cause IP field.
- Qualifies pending interrupts with Status IM/IE/EXL/ERL and raises a held request to the pipeline exception unit.
- The request is acknowledged when the exception is taken (the same pulse that sets EXL in Status); the block re-arms on ERET.

Parameters:
NHW, 6, number of hardware interrupt lines (maps to IP[7:2]; fixed at 6 for MIPS32 compat).
SYNC_STAGES, 2, synchronizer flops per hw_irq line (>=2).

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
hw_irq  in  NHW  asynchronous level interrupt lines, active-high
timer_irq  in  1  Count/Compare match level, already in clk domain
sw_ip  in  2  Cause IP[1:0] software interrupt bits
statusreg  in  32  current Status register (IE=0, EXL=1, ERL=2, IM=15:8)
irq_ack  in  1  pulse: pipeline took an exception this cycle (any cause)
eret  in  1  pulse: ERET committed
ip_pending  out  8  registered Cause IP[7:0] image
irq_req  out  1  interrupt request to exception unit (level, held)
irq_line  out  3  index of highest-priority enabled pending IP bit, stable while irq_req=1
irq_code  out  5  ExcCode for request, constant 5'd0 (Int)

Behaviour:
- Reset (reset_n=0 at a rising edge): all synchronizer flops=0, ip_pending=8'h00, state=IDLE, irq_req=0, irq_line=0. Reset in any state, including REQ, drops irq_req after that edge.
- Sync: each hw_irq bit passes through SYNC_STAGES flops; no edge detection, level semantics.
- ip_pending (registered every cycle): [7] = sync_hw[5] | timer_irq; [6:2] = sync_hw[4:0]; [1:0] = sw_ip.
- enabled = ip_pending & statusreg[15:8].
- eligible = statusreg[0] & ~statusreg[1] & ~statusreg[2] & (|enabled); combinational.
- Priority: IP7 highest, IP0 lowest. irq_line = index of the highest set bit of enabled.
- FSM, 3 states; irq_req = (state==REQ), registered Moore output.
  - IDLE:
    - irq_ack -> BLOCK; ack has priority.
    - else eligible -> REQ, latch irq_line.
  - REQ:
    - irq_ack -> BLOCK.
    - else ~eligible -> IDLE, withdraw: source dropped, or MTC0 cleared IE/IM, or EXL set.
    - else stay; irq_line is not updated while in REQ.
  - BLOCK (handler running, EXL set):
    - eret -> IDLE.
    - else statusreg[1]==0 & statusreg[2]==0 -> IDLE (software cleared EXL via MTC0).
    - else stay.
- Latency: hw_irq rising (setup met before edge 1) -> irq_req=1 after edge SYNC_STAGES+2; that is edge 4 at default.
  - timer_irq / sw_ip -> irq_req after edge 2.
- Simultaneous events:
  - irq_ack and eret in the same cycle: irq_ack wins -> BLOCK.
  - eret with a still-pending source: IDLE for one cycle, then REQ re-evaluated against the updated Status (IE=1, EXL=0).
- irq_code is held 0. The exception unit uses irq_req | other causes and pulses irq_ack.

Decomposition:
- Shared package cp0_pkg:
  - Status bit indices: ST_IE=0, ST_EXL=1, ST_ERL=2, ST_IM_LO=8, ST_IM_HI=15.
  - EXC_INT=5'd0.
  - FSM state encoding (IDLE/REQ/BLOCK).
- One sub-module: cp0_irq_sync, a parameterized SYNC_STAGES-flop synchronizer, instantiated for the hw_irq vector.

Test Plan:
1. Reset: hold reset_n=0 with hw_irq=6'h3F and statusreg=32'h0000FF01 -> ip_pending=0 and irq_req=0. Release reset -> ip_pending=8'hFC after 3 edges, irq_req=1 after 4 edges, irq_line=7.
2. Masking: statusreg=32'h00000401 (IM2 only), hw_irq=6'b000011 -> ip_pending=8'h0C, irq_line=2. Set statusreg=32'h00000001 while in REQ -> irq_req=0 after the next edge.
3. Handshake: in REQ, pulse irq_ack one cycle -> BLOCK, irq_req=0. Hold statusreg EXL=1 and keep the source asserted -> irq_req stays 0. Pulse eret with statusreg=32'h0000FF01 -> irq_req=1 two edges later.
4. Priority and stability: statusreg=32'h0000FF01, timer_irq=1 and sw_ip=2'b01 together -> irq_line=7. Drop timer_irq while in REQ -> still eligible via IP0, irq_line stays 7 until ack.
5. Simultaneous: in REQ, assert irq_ack and eret in the same cycle -> state BLOCK, irq_req=0.
6. Mid-operation reset: in REQ, pulse reset_n=0 for one cycle -> irq_req=0 and ip_pending=0 after that edge; the request is re-raised after SYNC_STAGES+2 edges if the source persists.

Source files
------------

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared definitions for the CP0 interrupt controller. Holds
//                the Status register bit positions, the Int exception code,
//                the request state encoding and a priority-encoder helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cp0_pkg;

    // Status register field positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_ERL   = 2;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    // ExcCode reported for an interrupt request
    localparam logic [4:0] EXC_INT = 5'd0;

    // Request state machine encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BLOCK = 2'd2
    } irq_state_t;

    // Index of the highest set bit; IP7 has the highest priority.
    // Returns 0 for an all-zero input, which is never used as a request.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_irq_sync
//  Description : Multi-flop level synchronizer for a vector of asynchronous
//                interrupt lines. No edge detection; each bit is a plain
//                STAGES-deep shift chain.
//  Ports       : clk     - system clock
//                reset_n - synchronous active-low reset, clears every stage
//                d       - asynchronous input vector
//                q       - synchronized output vector
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_irq_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 captures the asynchronous input; the last stage is the output.
    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cp0_intctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_intctrl
//  Description : CP0 interrupt pending/request stage. Synchronizes external
//                interrupt lines, builds the Cause IP[7:0] image, qualifies
//                it with Status IM/IE/EXL/ERL and holds a request to the
//                exception unit until it is acknowledged or withdrawn.
//  Ports       : clk        - system clock
//                reset_n    - synchronous active-low reset
//                hw_irq     - asynchronous level interrupt lines (IP[7:2])
//                timer_irq  - Count/Compare match, merged into IP7
//                sw_ip      - software interrupt bits IP[1:0]
//                statusreg  - current Status register
//                irq_ack    - exception taken this cycle
//                eret       - ERET committed this cycle
//                ip_pending - registered Cause IP[7:0] image
//                irq_req    - held interrupt request
//                irq_line   - IP index of the request, frozen while requesting
//                irq_code   - ExcCode for the request (always Int)
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_intctrl
    import cp0_pkg::*;
#(
    parameter int NHW         = 6,   // IP[7:2] mapping assumes 6 lines
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NHW-1:0] hw_irq,
    input  logic           timer_irq,
    input  logic [1:0]     sw_ip,
    input  logic [31:0]    statusreg,
    input  logic           irq_ack,
    input  logic           eret,
    output logic [7:0]     ip_pending,
    output logic           irq_req,
    output logic [2:0]     irq_line,
    output logic [4:0]     irq_code
);

    logic [NHW-1:0] w_sync_hw;
    logic [7:0]     w_enabled;
    logic           w_eligible;
    logic [2:0]     w_line;
    irq_state_t     r_state;

    cp0_irq_sync #(
        .WIDTH  (NHW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (hw_irq),
        .q       (w_sync_hw)
    );

    // Cause IP image; the timer shares IP7 with the top hardware line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ip_pending <= 8'h00;
        end else begin
            ip_pending <= {w_sync_hw[5] | timer_irq, w_sync_hw[4:0], sw_ip};
        end
    end

    assign w_enabled  = ip_pending & statusreg[ST_IM_HI:ST_IM_LO];
    assign w_eligible = statusreg[ST_IE] & ~statusreg[ST_EXL] &
                        ~statusreg[ST_ERL] & (|w_enabled);
    assign w_line     = prio_idx(w_enabled);

    // Status bits that play no part in interrupt qualification
    logic unused_status;
    assign unused_status = ^{statusreg[31:16], statusreg[7:3]};

    // Request FSM. irq_req is registered alongside the state so that it is
    // exactly (state == S_REQ) without a decode after the flop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            irq_req  <= 1'b0;
            irq_line <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // An exception taken for another cause still blocks us
                    // until the handler returns.
                    if (irq_ack) begin
                        r_state <= S_BLOCK;
                        irq_req <= 1'b0;
                    end else if (w_eligible) begin
                        r_state  <= S_REQ;
                        irq_req  <= 1'b1;
                        irq_line <= w_line;
                    end
                end
                S_REQ: begin
                    // irq_line is frozen here so the exception unit sees a
                    // stable cause even if sources change underneath.
                    if (irq_ack) begin
                        r_state <= S_BLOCK;
                        irq_req <= 1'b0;
                    end else if (!w_eligible) begin
                        r_state <= S_IDLE;
                        irq_req <= 1'b0;
                    end
                end
                S_BLOCK: begin
                    // Leave on ERET, or when software clears EXL/ERL itself.
                    if (eret || (!statusreg[ST_EXL] && !statusreg[ST_ERL])) begin
                        r_state <= S_IDLE;
                    end
                    irq_req <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

    assign irq_code = EXC_INT;

endmodule
`default_nettype wire

// File: tb/tb_cp0_intctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_intctrl
//  Description : Directed self-checking bench for cp0_intctrl. Inputs change
//                on the falling edge, outputs are sampled on the falling edge
//                after the rising edge of interest.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cp0_intctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  hw_irq;
    logic        timer_irq;
    logic [1:0]  sw_ip;
    logic [31:0] statusreg;
    logic        irq_ack;
    logic        eret;
    logic [7:0]  ip_pending;
    logic        irq_req;
    logic [2:0]  irq_line;
    logic [4:0]  irq_code;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cp0_intctrl #(
        .NHW         (6),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hw_irq     (hw_irq),
        .timer_irq  (timer_irq),
        .sw_ip      (sw_ip),
        .statusreg  (statusreg),
        .irq_ack    (irq_ack),
        .eret       (eret),
        .ip_pending (ip_pending),
        .irq_req    (irq_req),
        .irq_line   (irq_line),
        .irq_code   (irq_code)
    );

    // Advance n rising edges, landing on the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        hw_irq    = 6'h00;
        timer_irq = 1'b0;
        sw_ip     = 2'b00;
        statusreg = 32'h0000_0000;
        irq_ack   = 1'b0;
        eret      = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        hw_irq    = 6'h3F;
        timer_irq = 1'b0;
        sw_ip     = 2'b00;
        statusreg = 32'h0000_FF01;
        irq_ack   = 1'b0;
        eret      = 1'b0;
        cyc(3);
        total++; if (ip_pending !== 8'h00) $display("FAIL rst_ip: got %h want 00", ip_pending); else passed++;
        total++; if (irq_req !== 1'b0) $display("FAIL rst_req: got %b want 0", irq_req); else passed++;
        total++; if (irq_line !== 3'd0) $display("FAIL rst_line: got %0d want 0", irq_line); else passed++;
        total++; if (irq_code !== 5'd0) $display("FAIL rst_code: got %0d want 0", irq_code); else passed++;
        reset_n = 1'b1;
        cyc(2);
        total++; if (ip_pending !== 8'h00) $display("FAIL rst_ip_e2: got %h want 00", ip_pending); else passed++;
        cyc(1);
        total++; if (ip_pending !== 8'hFC) $display("FAIL rst_ip_e3: got %h want fc", ip_pending); else passed++;
        total++; if (irq_req !== 1'b0) $display("FAIL rst_req_e3: got %b want 0", irq_req); else passed++;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL rst_req_e4: got %b want 1", irq_req); else passed++;
        total++; if (irq_line !== 3'd7) $display("FAIL rst_line_e4: got %0d want 7", irq_line); else passed++;
    endtask

    task automatic test_masking();
        do_reset();
        statusreg = 32'h0000_0401;
        hw_irq    = 6'b000011;
        cyc(3);
        total++; if (ip_pending !== 8'h0C) $display("FAIL mask_ip: got %h want 0c", ip_pending); else passed++;
        total++; if (irq_req !== 1'b0) $display("FAIL mask_req_e3: got %b want 0", irq_req); else passed++;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL mask_req_e4: got %b want 1", irq_req); else passed++;
        total++; if (irq_line !== 3'd2) $display("FAIL mask_line: got %0d want 2", irq_line); else passed++;
        statusreg = 32'h0000_0001;
        cyc(1);
        total++; if (irq_req !== 1'b0) $display("FAIL mask_withdraw: got %b want 0", irq_req); else passed++;
    endtask

    task automatic test_exl_erl();
        do_reset();
        sw_ip     = 2'b01;
        statusreg = 32'h0000_FF03;   // EXL set
        cyc(3);
        total++; if (irq_req !== 1'b0) $display("FAIL exl_block: got %b want 0", irq_req); else passed++;
        statusreg = 32'h0000_FF05;   // ERL set
        cyc(2);
        total++; if (irq_req !== 1'b0) $display("FAIL erl_block: got %b want 0", irq_req); else passed++;
        statusreg = 32'h0000_FF00;   // IE clear
        cyc(2);
        total++; if (irq_req !== 1'b0) $display("FAIL ie_block: got %b want 0", irq_req); else passed++;
        statusreg = 32'h0000_FF01;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL ie_enable: got %b want 1", irq_req); else passed++;
        total++; if (irq_line !== 3'd0) $display("FAIL ie_line: got %0d want 0", irq_line); else passed++;
    endtask

    task automatic test_handshake();
        do_reset();
        statusreg = 32'h0000_FF01;
        timer_irq = 1'b1;
        cyc(2);
        total++; if (irq_req !== 1'b1) $display("FAIL hs_req: got %b want 1", irq_req); else passed++;
        irq_ack = 1'b1;
        cyc(1);
        irq_ack   = 1'b0;
        statusreg = 32'h0000_FF03;
        total++; if (irq_req !== 1'b0) $display("FAIL hs_ack: got %b want 0", irq_req); else passed++;
        cyc(3);
        total++; if (irq_req !== 1'b0) $display("FAIL hs_held: got %b want 0", irq_req); else passed++;
        eret      = 1'b1;
        statusreg = 32'h0000_FF01;
        cyc(1);
        eret = 1'b0;
        total++; if (irq_req !== 1'b0) $display("FAIL hs_eret_e1: got %b want 0", irq_req); else passed++;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL hs_eret_e2: got %b want 1", irq_req); else passed++;
    endtask

    task automatic test_mtc0_exit();
        do_reset();
        statusreg = 32'h0000_FF01;
        sw_ip     = 2'b10;
        cyc(2);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack   = 1'b0;
        statusreg = 32'h0000_FF03;
        cyc(2);
        total++; if (irq_req !== 1'b0) $display("FAIL mtc0_held: got %b want 0", irq_req); else passed++;
        statusreg = 32'h0000_FF01;   // software clears EXL, no ERET
        cyc(1);
        total++; if (irq_req !== 1'b0) $display("FAIL mtc0_e1: got %b want 0", irq_req); else passed++;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL mtc0_e2: got %b want 1", irq_req); else passed++;
        total++; if (irq_line !== 3'd1) $display("FAIL mtc0_line: got %0d want 1", irq_line); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        statusreg = 32'h0000_FF01;
        timer_irq = 1'b1;
        sw_ip     = 2'b01;
        cyc(1);
        total++; if (ip_pending !== 8'h81) $display("FAIL prio_ip: got %h want 81", ip_pending); else passed++;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL prio_req: got %b want 1", irq_req); else passed++;
        total++; if (irq_line !== 3'd7) $display("FAIL prio_line: got %0d want 7", irq_line); else passed++;
        timer_irq = 1'b0;
        cyc(3);
        total++; if (ip_pending !== 8'h01) $display("FAIL prio_ip_drop: got %h want 01", ip_pending); else passed++;
        total++; if (irq_req !== 1'b1) $display("FAIL prio_req_hold: got %b want 1", irq_req); else passed++;
        total++; if (irq_line !== 3'd7) $display("FAIL prio_line_hold: got %0d want 7", irq_line); else passed++;
        irq_ack = 1'b1;
        cyc(1);
        irq_ack   = 1'b0;
        statusreg = 32'h0000_FF03;
        cyc(1);
        eret      = 1'b1;
        statusreg = 32'h0000_FF01;
        cyc(1);
        eret = 1'b0;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL prio_rearm: got %b want 1", irq_req); else passed++;
        total++; if (irq_line !== 3'd0) $display("FAIL prio_rearm_line: got %0d want 0", irq_line); else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        statusreg = 32'h0000_FF01;
        sw_ip     = 2'b10;
        cyc(2);
        total++; if (irq_req !== 1'b1) $display("FAIL sim_req: got %b want 1", irq_req); else passed++;
        irq_ack = 1'b1;
        eret    = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        eret    = 1'b0;
        // Status left with EXL clear: BLOCK falls to IDLE, then REQ.
        total++; if (irq_req !== 1'b0) $display("FAIL sim_e1: got %b want 0", irq_req); else passed++;
        cyc(1);
        total++; if (irq_req !== 1'b0) $display("FAIL sim_e2: got %b want 0", irq_req); else passed++;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL sim_e3: got %b want 1", irq_req); else passed++;
    endtask

    task automatic test_back_to_back();
        // Ack arriving in IDLE while a source is eligible wins over the request
        do_reset();
        statusreg = 32'h0000_FF01;
        sw_ip     = 2'b01;
        irq_ack   = 1'b1;
        cyc(2);
        irq_ack   = 1'b0;
        statusreg = 32'h0000_FF03;
        total++; if (irq_req !== 1'b0) $display("FAIL b2b_idle_ack: got %b want 0", irq_req); else passed++;
        cyc(2);
        total++; if (irq_req !== 1'b0) $display("FAIL b2b_blocked: got %b want 0", irq_req); else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        statusreg = 32'h0000_FF01;
        hw_irq    = 6'b100000;
        cyc(4);
        total++; if (irq_req !== 1'b1) $display("FAIL mrst_req: got %b want 1", irq_req); else passed++;
        total++; if (ip_pending !== 8'h80) $display("FAIL mrst_ip: got %h want 80", ip_pending); else passed++;
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        total++; if (irq_req !== 1'b0) $display("FAIL mrst_drop: got %b want 0", irq_req); else passed++;
        total++; if (ip_pending !== 8'h00) $display("FAIL mrst_ip0: got %h want 00", ip_pending); else passed++;
        cyc(3);
        total++; if (irq_req !== 1'b0) $display("FAIL mrst_e3: got %b want 0", irq_req); else passed++;
        cyc(1);
        total++; if (irq_req !== 1'b1) $display("FAIL mrst_e4: got %b want 1", irq_req); else passed++;
        total++; if (irq_line !== 3'd7) $display("FAIL mrst_line: got %0d want 7", irq_line); else passed++;
    endtask

    initial begin
        reset_n   = 1'b0;
        hw_irq    = 6'h00;
        timer_irq = 1'b0;
        sw_ip     = 2'b00;
        statusreg = 32'h0;
        irq_ack   = 1'b0;
        eret      = 1'b0;
        test_reset();
        test_masking();
        test_exl_erl();
        test_handshake();
        test_mtc0_exit();
        test_priority();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
